float_addsub_pipe: RTL and testbench

//  Parametrised pipelined floating-point adder/subtractor for the neural datapath; successor to the fixed 12-bit adder.

---
 rtl/float_addsub_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_float_addsub_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_addsub_pipe.sv
// Pipelined float add/sub {sign,exp,man}, RNE, saturate/flush; 5 cycles, 1 op/cycle.
// Whole pipe stalls when out_valid_o & ~out_ready_i; FADD_STATUS_EN adds status_o {ovf,unf,zero}.
module float_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 op_sub_i,
  input  logic [EXP_W+MAN_W:0] data_a_i,
  input  logic [EXP_W+MAN_W:0] data_b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [EXP_W+MAN_W:0] data_o
`ifdef FADD_STATUS_EN
  ,
  output logic [2:0]           status_o
`endif
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 1;
  localparam int X   = MAN_W + 4;  // hidden+mantissa+guard/round/sticky
  localparam int EW2 = EXP_W + 2;
  localparam int LW  = $clog2(X + 1);

  logic w_adv;
  assign w_adv      = out_ready_i | ~out_valid_o;
  assign in_ready_o = w_adv;

  // S1: unpack, zero detect, order operands by magnitude
  logic             w_a_zero, w_b_zero, w_b_sign, w_a_big;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [SW-1:0]    w_a_sig, w_b_sig;
  logic             r_s1_vld, r_s1_sign, r_s1_sub;
  logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
  logic [SW-1:0]    r_s1_big, r_s1_small;

  always_comb begin
    w_a_zero = (data_a_i[W-2:0] == '0);
    w_b_zero = (data_b_i[W-2:0] == '0);
    w_a_exp  = w_a_zero ? '0 : data_a_i[W-2:MAN_W];
    w_b_exp  = w_b_zero ? '0 : data_b_i[W-2:MAN_W];
    w_a_sig  = w_a_zero ? '0 : {1'b1, data_a_i[MAN_W-1:0]};
    w_b_sig  = w_b_zero ? '0 : {1'b1, data_b_i[MAN_W-1:0]};
    w_b_sign = data_b_i[W-1] ^ op_sub_i;
    w_a_big  = ({w_a_exp, w_a_sig} >= {w_b_exp, w_b_sig});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_vld <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld <= in_valid_i;
    end
    if (w_adv) begin
      r_s1_sub <= data_a_i[W-1] ^ w_b_sign;
      if (w_a_big) begin
        r_s1_sign  <= data_a_i[W-1];
        r_s1_exp   <= w_a_exp;
        r_s1_big   <= w_a_sig;
        r_s1_small <= w_b_sig;
        r_s1_diff  <= w_a_exp - w_b_exp;
      end else begin
        r_s1_sign  <= w_b_sign;
        r_s1_exp   <= w_b_exp;
        r_s1_big   <= w_b_sig;
        r_s1_small <= w_a_sig;
        r_s1_diff  <= w_b_exp - w_a_exp;
      end
    end
  end

  // S2: align smaller operand, folding shifted-out bits into sticky
  logic [X-1:0]     w_small_ext, w_small_sh, w_lost_mask, w_aligned;
  logic             w_far;
  logic             r_s2_vld, r_s2_sign, r_s2_sub;
  logic [EXP_W-1:0] r_s2_exp;
  logic [X-1:0]     r_s2_big, r_s2_small;

  always_comb begin
    w_small_ext = {r_s1_small, 3'b000};
    w_small_sh  = w_small_ext >> r_s1_diff;
    w_lost_mask = ~({X{1'b1}} << r_s1_diff);
    w_far       = (32'(r_s1_diff) > 32'(MAN_W + 2));
    if (w_far) begin
      w_aligned = {{(X-1){1'b0}}, |r_s1_small};
    end else begin
      w_aligned = {w_small_sh[X-1:1], w_small_sh[0] | (|(w_small_ext & w_lost_mask))};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_vld <= 1'b0;
    end else if (w_adv) begin
      r_s2_vld <= r_s1_vld;
    end
    if (w_adv) begin
      r_s2_sign  <= r_s1_sign;
      r_s2_sub   <= r_s1_sub;
      r_s2_exp   <= r_s1_exp;
      r_s2_big   <= {r_s1_big, 3'b000};
      r_s2_small <= w_aligned;
    end
  end

  // S3: magnitude add/subtract; larger operand is never smaller than aligned one
  logic             r_s3_vld, r_s3_sign;
  logic [EXP_W-1:0] r_s3_exp;
  logic [X:0]       r_s3_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s3_vld <= 1'b0;
    end else if (w_adv) begin
      r_s3_vld <= r_s2_vld;
    end
    if (w_adv) begin
      r_s3_sign <= r_s2_sign;
      r_s3_exp  <= r_s2_exp;
      r_s3_sum  <= r_s2_sub ? ({1'b0, r_s2_big} - {1'b0, r_s2_small})
                            : ({1'b0, r_s2_big} + {1'b0, r_s2_small});
    end
  end

  // S4: leading-one detect, normalise so the hidden bit sits at X-1
  logic [LW-1:0]    w_lead;
  logic [X-1:0]     w_norm;
  logic [EW2-1:0]   w_s4_exp;
  logic             r_s4_vld, r_s4_sign, r_s4_zero;
  logic [EW2-1:0]   r_s4_exp;
  logic [X-1:0]     r_s4_norm;

  always_comb begin
    w_lead = '0;
    for (int i = 0; i <= X; i++) begin
      if (r_s3_sum[i]) w_lead = LW'(i);
    end
    if (r_s3_sum[X]) begin
      w_norm = {r_s3_sum[X:2], r_s3_sum[1] | r_s3_sum[0]};
    end else begin
      w_norm = r_s3_sum[X-1:0] << (LW'(X - 1) - w_lead);
    end
    w_s4_exp = EW2'(r_s3_exp) + EW2'(w_lead) - EW2'(X - 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s4_vld <= 1'b0;
    end else if (w_adv) begin
      r_s4_vld <= r_s3_vld;
    end
    if (w_adv) begin
      r_s4_sign <= r_s3_sign;
      r_s4_zero <= (r_s3_sum == '0);
      r_s4_exp  <= w_s4_exp;
      r_s4_norm <= w_norm;
    end
  end

  // S5: ties-to-even rounding, exponent range handling, pack
  logic [MAN_W+1:0] w_rnd;
  logic [MAN_W-1:0] w_man;
  logic [EW2-1:0]   w_exp5;
  logic             w_rup, w_ovf, w_unf;
  logic [W-1:0]     w_res;
  logic             r_out_vld;
  logic [W-1:0]     r_data;

  always_comb begin
    w_rup  = r_s4_norm[2] & (r_s4_norm[1] | r_s4_norm[0] | r_s4_norm[3]);
    w_rnd  = {1'b0, r_s4_norm[X-1:3]} + (MAN_W + 2)'(w_rup);
    w_man  = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    w_exp5 = r_s4_exp + EW2'(w_rnd[MAN_W+1]);
    w_ovf  = ~r_s4_zero & ~w_exp5[EW2-1] & (w_exp5 > EW2'((1 << EXP_W) - 1));
    w_unf  = ~r_s4_zero & (w_exp5[EW2-1] | (w_exp5 == '0));
    if (r_s4_zero || w_unf) begin
      w_res = '0;
    end else if (w_ovf) begin
      w_res = {r_s4_sign, {(W-1){1'b1}}};
    end else begin
      w_res = {r_s4_sign, w_exp5[EXP_W-1:0], w_man};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_vld <= 1'b0;
      r_data    <= '0;
    end else if (w_adv) begin
      r_out_vld <= r_s4_vld;
      if (r_s4_vld) r_data <= w_res;
    end
  end

  assign out_valid_o = r_out_vld;
  assign data_o      = r_data;

`ifdef FADD_STATUS_EN
  logic [2:0] r_status;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_status <= 3'b000;
    end else if (w_adv && r_s4_vld) begin
      r_status <= {w_ovf, w_unf, r_s4_zero | w_unf};
    end
  end
  assign status_o = r_status;
`endif

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Scoreboard bench for float_addsub_pipe (EXP_W=5, MAN_W=6): directed table, random ops with
// backpressure, a forced output stall and a mid-flight reset.
module tb_float_addsub_pipe;
  logic        clk_i = 1'b0;
  logic        rst_i, in_valid_i, op_sub_i, in_ready_o, out_valid_o, out_ready_i;
  logic [11:0] data_a_i, data_b_i, data_o;
`ifdef FADD_STATUS_EN
  logic [2:0]  status_o;
`endif
  logic        stall, bp_mode;
  logic        rnd_ok = 1'b1;
  int          cyc = 0;
  int          n_total, n_bad;

  typedef struct { logic [11:0] d; logic [2:0] st; int stamp; bit lat; } sb_t;
  sb_t sb[$];

  localparam int ND = 13;
  logic [11:0] t_a  [ND] = '{12'h3C0, 12'h3C0, 12'h420, 12'h7FF, 12'hFFF, 12'h041, 12'h3C0,
                             12'h000, 12'h7C0, 12'h3C0, 12'h3C1, 12'h7FF, 12'h3C0};
  logic [11:0] t_b  [ND] = '{12'h3C0, 12'h3C0, 12'h400, 12'h7FF, 12'hFFF, 12'h040, 12'h000,
                             12'h3C0, 12'h040, 12'h3C1, 12'h3C2, 12'h7C0, 12'h380};
  logic        t_s  [ND] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [11:0] t_d  [ND] = '{12'h400, 12'h000, 12'h3C0, 12'h7FF, 12'hFFF, 12'h000, 12'h3C0,
                             12'hBC0, 12'h7C0, 12'h400, 12'h402, 12'h7FF, 12'h380};
  logic [2:0]  t_st [ND] = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b100, 3'b011, 3'b000,
                             3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};

  float_addsub_pipe #(.EXP_W(5), .MAN_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_sub_i(op_sub_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_o(data_o)
`ifdef FADD_STATUS_EN
    , .status_o(status_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) begin
    #1;
    rnd_ok = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  assign out_ready_i = rnd_ok & ~stall;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic real pow2(int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real dec(logic [11:0] v);
    real m;
    if (v[10:0] == 11'd0) return 0.0;
    m = (1.0 + real'(v[5:0]) / 64.0) * pow2(int'(v[10:6]) - 15);
    return v[11] ? -m : m;
  endfunction

  // Exact real sum, then round-to-nearest-even onto the 5/6 format: {status, data}
  function automatic logic [14:0] model(logic [11:0] a, logic [11:0] b, logic sub);
    real x, m, rem;
    int  e, be, q;
    logic s;
    x = dec(a) + (sub ? -dec(b) : dec(b));
    if (x == 0.0) return {3'b001, 12'h000};
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    q   = $rtoi(m * 64.0);
    rem = m * 64.0 - real'(q);
    if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
    if (q == 128) begin q = 64; e++; end
    be = e + 15;
    if (be > 31) return {3'b100, s, 11'h7FF};
    if (be < 1) return {3'b011, 12'h000};
    return {3'b000, s, be[4:0], q[5:0]};
  endfunction

  function automatic logic [11:0] rnd_op();
    return 12'($urandom_range(0, 4095));
  endfunction

  function automatic logic [11:0] rnd_near(logic [11:0] a);
    logic [11:0] b;
    b = rnd_op();
    if ($urandom_range(0, 1) == 1) b[10:6] = a[10:6] ^ 5'($urandom_range(0, 3));
    return b;
  endfunction

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic sub,
                      input logic [11:0] ed, input logic [2:0] est, input bit lat);
    sb_t e;
    bit  ok = 1'b0;
    int  stamp = 0;
    data_a_i = a; data_b_i = b; op_sub_i = sub; in_valid_i = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk_i);
      ok    = in_ready_o;
      stamp = cyc;
      @(posedge clk_i);
      #1;
    end
    check_eq("accept", int'(ok), 1);
    if (ok) begin
      e.d = ed; e.st = est; e.stamp = stamp; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic send_model(input logic [11:0] a, input logic [11:0] b, input logic sub, input bit lat);
    logic [14:0] r;
    r = model(a, b, sub);
    send(a, b, sub, r[11:0], r[14:12], lat);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin @(negedge clk_i); n++; end
    check_eq("drain", sb.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    sb_t e;
    if (!rst_i && out_valid_o && out_ready_i) begin
      check_eq("sb_nonempty", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("data", int'(data_o), int'(e.d));
`ifdef FADD_STATUS_EN
        check_eq("status", int'(status_o), int'(e.st));
`endif
        if (e.lat) check_eq("latency", cyc - e.stamp, 5);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0;
    rst_i = 1'b1; in_valid_i = 1'b0; op_sub_i = 1'b0;
    data_a_i = '0; data_b_i = '0; stall = 1'b0; bp_mode = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("reset_vld", int'(out_valid_o), 0);
    check_eq("reset_dat", int'(data_o), 0);
`ifdef FADD_STATUS_EN
    check_eq("reset_status", int'(status_o), 0);
`endif
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("reset_rdy", int'(in_ready_o), 1);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < ND; i++) send(t_a[i], t_b[i], t_s[i], t_d[i], t_st[i], 1'b1);
    in_valid_i = 1'b0;
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [11:0] a;
      a = rnd_op();
      send_model(a, rnd_near(a), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
      end
    end
    in_valid_i = 1'b0;
    drain();
    bp_mode = 1'b0;
    @(posedge clk_i);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [11:0] a;
          a = rnd_op();
          send_model(a, rnd_near(a), 1'($urandom_range(0, 1)), 1'b0);
        end
        in_valid_i = 1'b0;
      end
      begin : stall_blk
        int n;
        logic [11:0] held;
        n = 0;
        held = '0;
        while (!out_valid_o && n < 50) begin @(negedge clk_i); n++; end
        check_eq("stall_fill", int'(out_valid_o), 1);
        @(posedge clk_i);
        #1 stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_i);
          check_eq("stall_rdy", int'(in_ready_o), 0);
          check_eq("stall_vld", int'(out_valid_o), 1);
          if (k == 0) held = data_o;
          else check_eq("stall_hold", int'(data_o), int'(held));
        end
        @(posedge clk_i);
        #1 stall = 1'b0;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send_model(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0);
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sb.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("midrst_vld", int'(out_valid_o), 0);
    check_eq("midrst_dat", int'(data_o), 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (15) @(negedge clk_i);
    check_eq("midrst_idle", int'(out_valid_o), 0);

    @(posedge clk_i);
    #1;
    send(12'h3C0, 12'h3C0, 1'b0, 12'h400, 3'b000, 1'b1);
    in_valid_i = 1'b0;
    drain();
    check_eq("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
